// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronized, glitch-filtered A/B phases driving step/dir pulses and a wrapping position count.
// Optional index input and index_seen flag are built when QUAD_INDEX_EN is defined.
module quad_decoder #(
    parameter int N           = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         quad_a,
    input  logic         quad_b,
    input  logic         en,
    input  logic         clr,
`ifdef QUAD_INDEX_EN
    input  logic         quad_z,
    output logic         index_seen,
`endif
    output logic         step,
    output logic         dir,
    output logic [N-1:0] count,
    output logic         err
);

`ifdef QUAD_INDEX_EN
    localparam int NPH = 3;
`else
    localparam int NPH = 2;
`endif
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] FILT_LAST = CW'(FILT_LEN - 1);
    localparam logic [CW-1:0] FCNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  CNT_ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2:0]    SETTLED   = 3'(SYNC_STAGES);

    logic [NPH-1:0]         w_pin;
    logic [NPH-1:0]         w_sync;
    logic [SYNC_STAGES-1:0] r_sync [NPH];
    logic [CW-1:0]          r_fcnt [NPH];
    logic [NPH-1:0]         r_filt;

    logic [1:0]   r_prev;
    logic [2:0]   r_settle;
    logic         r_init;
    logic         r_step;
    logic         r_dir;
    logic [N-1:0] r_count;
    logic         r_err;

    logic [1:0] w_cur_ab;
    logic [1:0] w_sync_ab;
    logic [1:0] w_delta;
    logic       w_up;
    logic       w_dn;
    logic       w_ill;
    logic       w_settled;
    logic       w_idx;

    // Phase bit 0 = A, bit 1 = B, bit 2 = Z (index build only)
`ifdef QUAD_INDEX_EN
    assign w_pin = {quad_z, quad_b, quad_a};
`else
    assign w_pin = {quad_b, quad_a};
`endif

    for (genvar g = 0; g < NPH; g++) begin : g_sync
        assign w_sync[g] = r_sync[g][SYNC_STAGES-1];
    end

    // A level is accepted only after FILT_LEN consecutive samples that differ from the held level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPH; i++) begin
                r_sync[i] <= '0;
                r_fcnt[i] <= '0;
            end
            r_filt <= '0;
        end else begin
            for (int i = 0; i < NPH; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_pin[i]};
                if (w_sync[i] != r_filt[i]) begin
                    if (r_fcnt[i] == FILT_LAST) begin
                        r_filt[i] <= w_sync[i];
                        r_fcnt[i] <= '0;
                    end else begin
                        r_fcnt[i] <= r_fcnt[i] + FCNT_ONE;
                    end
                end else begin
                    r_fcnt[i] <= '0;
                end
            end
        end
    end

    function automatic logic [1:0] gray2pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    assign w_cur_ab  = {r_filt[0], r_filt[1]};
    assign w_sync_ab = {w_sync[0], w_sync[1]};
    assign w_delta   = gray2pos(w_cur_ab) - gray2pos(r_prev);
    assign w_up      = (w_delta == 2'd1);
    assign w_dn      = (w_delta == 2'd3);
    assign w_ill     = (w_delta == 2'd2);
    assign w_settled = (r_settle == SETTLED);

    // Init holds until the synchronizer has filled and the filter has caught up with the pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= 2'b00;
            r_settle <= 3'd0;
            r_init   <= 1'b1;
            r_step   <= 1'b0;
            r_dir    <= 1'b0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (!w_settled)
                r_settle <= r_settle + 3'd1;
            r_prev <= w_cur_ab;
            r_step <= 1'b0;
            r_err  <= 1'b0;
            if (r_init) begin
                if (w_settled && (w_sync_ab == w_cur_ab))
                    r_init <= 1'b0;
            end else begin
                if (w_up || w_dn) begin
                    r_dir  <= w_up;
                    r_step <= en;
                    if (en)
                        r_count <= w_up ? (r_count + CNT_ONE) : (r_count - CNT_ONE);
                end
                if (w_ill)
                    r_err <= 1'b1;
            end
            if (clr || w_idx)
                r_count <= '0;
        end
    end

`ifdef QUAD_INDEX_EN
    logic r_zprev;
    logic r_idx_seen;

    assign w_idx = r_filt[2] & ~r_zprev & ~r_init;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zprev    <= 1'b0;
            r_idx_seen <= 1'b0;
        end else begin
            r_zprev <= r_filt[2];
            if (w_idx)
                r_idx_seen <= 1'b1;
        end
    end

    assign index_seen = r_idx_seen;
`else
    assign w_idx = 1'b0;
`endif

    assign step  = r_step;
    assign dir   = r_dir;
    assign count = r_count;
    assign err   = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus randomized moves against a phase-position model.
module tb_quad_decoder;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        quad_a;
    logic        quad_b;
    logic        en;
    logic        clr;
    logic        step;
    logic        dir;
    logic [15:0] count;
    logic        err;
`ifdef QUAD_INDEX_EN
    logic        quad_z;
    logic        index_seen;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Observations from the last watch window
    int w_nstep, w_nerr, w_first_step, w_first_err;

    // Model: position along the quadrature cycle, expected count/dir, expected pulses per move
    int          m_pos;
    logic [15:0] m_count;
    logic        m_dir;
    int          m_nstep, m_nerr;

    always #5 clk = ~clk;

    quad_decoder #(.N(16), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .quad_a(quad_a), .quad_b(quad_b), .en(en), .clr(clr),
`ifdef QUAD_INDEX_EN
        .quad_z(quad_z), .index_seen(index_seen),
`endif
        .step(step), .dir(dir), .count(count), .err(err)
    );

    function automatic logic [1:0] pins_of(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic watch(input int hold, input int clr_at);
        w_nstep = 0; w_nerr = 0; w_first_step = 0; w_first_err = 0;
        for (int k = 1; k <= hold; k++) begin
            clr = (k == clr_at);
            @(posedge clk); #1;
            clr = 1'b0;
            if (step === 1'b1) begin w_nstep++; if (w_first_step == 0) w_first_step = k; end
            if (err === 1'b1) begin w_nerr++; if (w_first_err == 0) w_first_err = k; end
        end
    endtask

    // mv: +1 up, -1 down, 2 illegal double change, 0 no change
    task automatic move(input int mv, input logic en_v, input int hold, input int clr_at);
        logic legal;
        legal = (mv == 1) || (mv == -1);
        m_pos = (m_pos + mv + 4) % 4;
        m_nstep = (legal && en_v) ? 1 : 0;
        m_nerr  = (mv == 2) ? 1 : 0;
        if (legal) begin
            m_dir = (mv == 1);
            if (en_v) m_count = (mv == 1) ? m_count + 16'd1 : m_count - 16'd1;
        end
        if (clr_at > 0) begin
            if (clr_at < LAT && legal && en_v) m_count = (mv == 1) ? 16'h0001 : 16'hFFFF;
            else m_count = 16'h0000;
        end
        @(negedge clk);
        en = en_v;
        {quad_a, quad_b} = pins_of(m_pos);
        watch(hold, clr_at);
    endtask

    task automatic do_reset(input int p);
        @(negedge clk);
        rst_n = 1'b0;
        m_pos = p;
        {quad_a, quad_b} = pins_of(p);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_count = 16'h0000;
        m_dir = 1'b0;
        watch(12, 0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL reset_step: got %b want 0", step); end
        n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL reset_dir: got %b want 0", dir); end
        n_cmp++; if (count !== 16'h0000) begin n_bad++; $display("FAIL reset_count: got %h want 0000", count); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        watch(12, 0);
        n_cmp++; if (w_nstep !== 0 || w_nerr !== 0) begin n_bad++; $display("FAIL post_reset_quiet: steps %0d errs %0d want 0 0", w_nstep, w_nerr); end
    endtask

    task automatic test_up();
        for (int i = 0; i < 8; i++) begin
            move(1, 1'b1, 10, 0);
            n_cmp++; if (w_nstep !== 1) begin n_bad++; $display("FAIL up_steps[%0d]: got %0d want 1", i, w_nstep); end
            n_cmp++; if (w_first_step !== LAT) begin n_bad++; $display("FAIL up_latency[%0d]: got %0d want %0d", i, w_first_step, LAT); end
            n_cmp++; if (w_nerr !== 0) begin n_bad++; $display("FAIL up_err[%0d]: got %0d want 0", i, w_nerr); end
            n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL up_dir[%0d]: got %b want 1", i, dir); end
            n_cmp++; if (count !== m_count) begin n_bad++; $display("FAIL up_count[%0d]: got %h want %h", i, count, m_count); end
        end
        n_cmp++; if (count !== 16'd8) begin n_bad++; $display("FAIL up_total: got %h want 0008", count); end
    endtask

    task automatic test_down_wrap();
        do_reset(0);
        move(-1, 1'b1, 10, 0);
        n_cmp++; if (count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_down_count: got %h want ffff", count); end
        n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL wrap_down_dir: got %b want 0", dir); end
        n_cmp++; if (w_nstep !== 1) begin n_bad++; $display("FAIL wrap_down_step: got %0d want 1", w_nstep); end
        move(1, 1'b1, 10, 0);
        n_cmp++; if (count !== 16'h0000) begin n_bad++; $display("FAIL wrap_up_count: got %h want 0000", count); end
        n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL wrap_up_dir: got %b want 1", dir); end
    endtask

    task automatic test_glitch();
        int s, e;
        @(negedge clk);
        quad_a = ~quad_a;
        watch(2, 0);
        s = w_nstep; e = w_nerr;
        @(negedge clk);
        quad_a = ~quad_a;
        watch(12, 0);
        n_cmp++; if (s + w_nstep !== 0) begin n_bad++; $display("FAIL glitch_step: got %0d want 0", s + w_nstep); end
        n_cmp++; if (e + w_nerr !== 0) begin n_bad++; $display("FAIL glitch_err: got %0d want 0", e + w_nerr); end
        n_cmp++; if (count !== m_count) begin n_bad++; $display("FAIL glitch_count: got %h want %h", count, m_count); end
    endtask

    task automatic test_illegal();
        move(2, 1'b1, 10, 0);
        n_cmp++; if (w_nerr !== 1) begin n_bad++; $display("FAIL illegal_err: got %0d want 1", w_nerr); end
        n_cmp++; if (w_first_err !== LAT) begin n_bad++; $display("FAIL illegal_err_latency: got %0d want %0d", w_first_err, LAT); end
        n_cmp++; if (w_nstep !== 0) begin n_bad++; $display("FAIL illegal_step: got %0d want 0", w_nstep); end
        n_cmp++; if (count !== m_count) begin n_bad++; $display("FAIL illegal_count: got %h want %h", count, m_count); end
        move(1, 1'b1, 10, 0);
        n_cmp++; if (w_nstep !== 1 || w_nerr !== 0) begin n_bad++; $display("FAIL after_illegal_step: steps %0d errs %0d want 1 0", w_nstep, w_nerr); end
        n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL after_illegal_dir: got %b want 1", dir); end
        n_cmp++; if (count !== m_count) begin n_bad++; $display("FAIL after_illegal_count: got %h want %h", count, m_count); end
    endtask

    task automatic test_rest11_en_clr();
        @(negedge clk);
        rst_n = 1'b0;
        m_pos = 2;
        {quad_a, quad_b} = pins_of(m_pos);
        #1;
        n_cmp++; if (count !== 16'h0000) begin n_bad++; $display("FAIL async_reset_count: got %h want 0000", count); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_count = 16'h0000;
        m_dir = 1'b0;
        watch(15, 0);
        n_cmp++; if (w_nstep !== 0 || w_nerr !== 0) begin n_bad++; $display("FAIL rest11_events: steps %0d errs %0d want 0 0", w_nstep, w_nerr); end
        n_cmp++; if (count !== 16'h0000) begin n_bad++; $display("FAIL rest11_count: got %h want 0000", count); end
        for (int i = 0; i < 4; i++) begin
            move(1, 1'b0, 10, 0);
            n_cmp++; if (w_nstep !== 0) begin n_bad++; $display("FAIL en0_step[%0d]: got %0d want 0", i, w_nstep); end
            n_cmp++; if (count !== m_count) begin n_bad++; $display("FAIL en0_count[%0d]: got %h want %h", i, count, m_count); end
            n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL en0_dir[%0d]: got %b want 1", i, dir); end
        end
        move(1, 1'b1, 10, LAT);
        n_cmp++; if (w_nstep !== 1) begin n_bad++; $display("FAIL clr_step: got %0d want 1", w_nstep); end
        n_cmp++; if (count !== 16'h0000) begin n_bad++; $display("FAIL clr_count: got %h want 0000", count); end
    endtask

`ifdef QUAD_INDEX_EN
    task automatic test_index();
        do_reset(0);
        n_cmp++; if (index_seen !== 1'b0) begin n_bad++; $display("FAIL index_seen_reset: got %b want 0", index_seen); end
        for (int i = 0; i < 5; i++) move(1, 1'b1, 10, 0);
        n_cmp++; if (count !== 16'd5) begin n_bad++; $display("FAIL index_pre_count: got %h want 0005", count); end
        @(negedge clk);
        m_pos = (m_pos + 1) % 4;
        {quad_a, quad_b} = pins_of(m_pos);
        quad_z = 1'b1;
        watch(10, 0);
        m_count = 16'h0000;
        m_dir = 1'b1;
        n_cmp++; if (w_nstep !== 1) begin n_bad++; $display("FAIL index_step: got %0d want 1", w_nstep); end
        n_cmp++; if (count !== 16'h0000) begin n_bad++; $display("FAIL index_count: got %h want 0000", count); end
        n_cmp++; if (index_seen !== 1'b1) begin n_bad++; $display("FAIL index_seen_set: got %b want 1", index_seen); end
        @(negedge clk);
        quad_z = 1'b0;
        watch(10, 0);
        move(1, 1'b1, 10, 0);
        @(negedge clk);
        quad_z = 1'b1;
        watch(10, 0);
        m_count = 16'h0000;
        n_cmp++; if (count !== 16'h0000) begin n_bad++; $display("FAIL index_again_count: got %h want 0000", count); end
        n_cmp++; if (index_seen !== 1'b1) begin n_bad++; $display("FAIL index_seen_hold: got %b want 1", index_seen); end
        @(negedge clk);
        quad_z = 1'b0;
        watch(10, 0);
    endtask
`endif

    task automatic test_random();
        int mv, hold, clr_at;
        logic en_v;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0, 1: mv = 1;
                2, 3: mv = -1;
                4:    mv = 2;
                default: mv = 0;
            endcase
            en_v   = (mv == 2) ? 1'b1 : ($urandom_range(0, 4) != 0);
            hold   = 7 + $urandom_range(0, 4);
            clr_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, hold) : 0;
            move(mv, en_v, hold, clr_at);
            n_cmp++; if (w_nstep !== m_nstep) begin n_bad++; $display("FAIL rnd_step[%0d]: got %0d want %0d (mv %0d)", i, w_nstep, m_nstep, mv); end
            n_cmp++; if (w_nerr !== m_nerr) begin n_bad++; $display("FAIL rnd_err[%0d]: got %0d want %0d (mv %0d)", i, w_nerr, m_nerr, mv); end
            n_cmp++; if (dir !== m_dir) begin n_bad++; $display("FAIL rnd_dir[%0d]: got %b want %b", i, dir, m_dir); end
            n_cmp++; if (count !== m_count) begin n_bad++; $display("FAIL rnd_count[%0d]: got %h want %h (clr_at %0d)", i, count, m_count, clr_at); end
        end
    endtask

    initial begin
        rst_n = 1'b0; quad_a = 1'b0; quad_b = 1'b0; en = 1'b1; clr = 1'b0;
`ifdef QUAD_INDEX_EN
        quad_z = 1'b0;
`endif
        m_pos = 0; m_count = 16'h0000; m_dir = 1'b0; m_nstep = 0; m_nerr = 0;
        test_reset();
        test_up();
        test_down_wrap();
        test_glitch();
        test_illegal();
        test_rest11_en_clr();
`ifdef QUAD_INDEX_EN
        test_index();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature decoder: receives the two-phase A/B signals from a rotary or linear encoder and produces a direction flag, a one-cycle step pulse, and an N-bit up/down position count.
- It is the receiving end of the encoder interface. Its step/dir outputs directly drive the team's up/down counting logic.
- Inputs are asynchronous to clk and are synchronized and glitch-filtered inside the block.

Parameters:
- N, 16, width of position counter count.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (legal values 2..4).
- FILT_LEN, 3, consecutive identical synchronized samples needed before a new level is accepted (legal values 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- quad_a  input  1  encoder phase A, asynchronous.
- quad_b  input  1  encoder phase B, asynchronous.
- en  input  1  count enable.
- clr  input  1  synchronous clear of count.
- step  output  1  one-cycle pulse per valid quadrature transition.
- dir  output  1  direction of the last valid transition: 1 = up, 0 = down.
- count  output  N  signed-agnostic position count, wraps modulo 2^N.
- err  output  1  one-cycle pulse on an illegal transition (both phases change at once).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All synchronizer and filter flops cleared; filtered state = 00.
  - step=0, dir=0, count=0, err=0.
  - Internal init flag set.
- Synchronizer: quad_a and quad_b each pass through SYNC_STAGES flops.
- Filter:
  - Each phase has a stability counter.
  - A new synchronized level is accepted into the filtered state only after FILT_LEN consecutive identical samples differing from the current filtered level.
  - Any reversion before that restarts the counter, so glitches shorter than FILT_LEN cycles are suppressed.
- Decode: compare the previous filtered state {A,B} with the new one.
  - Up sequence: 00→01→11→10→00.
  - Down sequence: 00→10→11→01→00.
  - No change: no action.
  - Both bits change (00↔11, 01↔10): err=1 for one cycle. count and dir unchanged, step=0. The filtered state still takes the new value.
- Latency: from the first rising edge that samples a new pin level to step=1 and count updated is SYNC_STAGES+FILT_LEN+1 rising edges (6 with defaults). step, dir and count update in the same cycle.
- Init: the first accepted filtered state after reset is loaded without producing step or err, and the init flag is then cleared. This means pins resting at 11 after reset produce no spurious event.
- en=0: decode still tracks state, so no err on resume. step stays 0 and count is held. dir still updates.
- clr=1: count=0 on the next edge. This takes priority over a coincident step, but step and dir still report that transition.
- Wrap: all-ones +1 → 0; 0 −1 → all-ones. No saturation and no flag.
- Maximum input rate: one filtered transition per FILT_LEN+1 cycles. Faster inputs are treated as glitches.

Optional Feature:
- Macro: QUAD_INDEX_EN.
- Defined:
  - Adds input quad_z (1 bit, asynchronous index pulse), synchronized and filtered identically to A/B.
  - On a rising edge of filtered Z, count loads 0. This takes priority over a coincident step; clr and index together also give 0.
  - Adds output index_seen (1 bit), set by the first index edge after reset and cleared only by rst_n.
- Undefined: no quad_z and no index_seen ports; no index logic.

Test Plan:
- Reset then 8 up transitions (00,01,11,10,00,...) spaced 10 cycles apart → 8 step pulses, dir=1, count=8. Each step arrives 6 edges after the pin change.
- From count=0, one down transition 00→10 → count=0xFFFF, dir=0. Then one up transition → count=0x0000.
- 2-cycle glitch on quad_a (0→1→0) → no step, no err, count unchanged.
- Jump 00→11 held 10 cycles → err pulses once, step=0, count unchanged. Following 11→10 → step, dir=1, count+1.
- Pins at 11 during reset, release rst_n → no step, no err, count=0. en=0 during 4 up transitions → count held, no step. Then clr coincident with an up transition → count=0, step=1.
- QUAD_INDEX_EN: count=5, Z rising edge coincident with an up step → count=0, index_seen=1. A later Z pulse keeps index_seen=1.
